// File: rtl/fnd_pkg.sv
// Shared constants for the FND scan decoder: segment patterns, digit codes,
// one-cold digit enables, FSM state encodings and small an-bus helpers.
package fnd_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_H     = 7'h09;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_P     = 7'h0C;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] CODE_A     = 4'hA;
    localparam logic [3:0] CODE_H     = 4'hB;
    localparam logic [3:0] CODE_C     = 4'hC;
    localparam logic [3:0] CODE_P     = 4'hD;
    localparam logic [3:0] CODE_E     = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam logic [3:0] AN_D1    = 4'b1110;
    localparam logic [3:0] AN_D10   = 4'b1101;
    localparam logic [3:0] AN_D100  = 4'b1011;
    localparam logic [3:0] AN_D1000 = 4'b0111;
    localparam logic [3:0] AN_NONE  = 4'b1111;

    localparam logic [1:0] WAIT   = 2'd0;
    localparam logic [1:0] STABLE = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    function automatic logic an_one_cold(input logic [3:0] a);
        return $countones(a) == 3;
    endfunction

    function automatic logic an_multi_low(input logic [3:0] a);
        return $countones(a) <= 2;
    endfunction

    // Digit position 0 = d1 .. 3 = d1000; only meaningful for one-cold inputs
    function automatic logic [1:0] an_index(input logic [3:0] a);
        case (a)
            AN_D10:   return 2'd1;
            AN_D100:  return 2'd2;
            AN_D1000: return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fnd_seg_decode.sv
// Combinational decode of an active-low 7-segment pattern into a 4-bit code
// plus an "unknown pattern" flag; blank decodes to code F without the flag.
module fnd_seg_decode
    import fnd_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [4:0] result
);

    always_comb begin
        result = {1'b0, CODE_BLANK};
        case (pattern)
            SEG_0:     result = {1'b0, 4'd0};
            SEG_1:     result = {1'b0, 4'd1};
            SEG_2:     result = {1'b0, 4'd2};
            SEG_3:     result = {1'b0, 4'd3};
            SEG_4:     result = {1'b0, 4'd4};
            SEG_5:     result = {1'b0, 4'd5};
            SEG_6:     result = {1'b0, 4'd6};
            SEG_7:     result = {1'b0, 4'd7};
            SEG_8:     result = {1'b0, 4'd8};
            SEG_9:     result = {1'b0, 4'd9};
            SEG_A:     result = {1'b0, CODE_A};
            SEG_H:     result = {1'b0, CODE_H};
            SEG_C:     result = {1'b0, CODE_C};
            SEG_P:     result = {1'b0, CODE_P};
            SEG_E:     result = {1'b0, CODE_E};
            SEG_BLANK: result = {1'b0, CODE_BLANK};
            default:   result = {1'b1, CODE_BLANK};
        endcase
    end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Rebuilds the 4-digit image from a multiplexed active-low an/seg display bus.
// Define FND_SCAN_BIN_EN to add the BCD-to-binary converter (bin_value/bin_valid).
module fnd_scan_decoder
    import fnd_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 400_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    output logic [15:0] digit_code,
    output logic [3:0]  dp,
    output logic [3:0]  digit_unk,
    output logic        frame_valid,
    output logic        frame_num,
    output logic        scan_error,
    output logic        stale
`ifdef FND_SCAN_BIN_EN
    ,
    output logic [13:0] bin_value,
    output logic        bin_valid
`endif
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [3:0]    an_q, an_p;
    logic [7:0]    seg_q, seg_p;
    logic [1:0]    state;
    logic [CW-1:0] stable_cnt;
    logic [7:0]    shadow [4];
    logic [3:0]    mask;
    logic [TW-1:0] stale_cnt;
    logic [4:0]    dec [4];
    logic          an_cold, an_multi, same, capture, commit, next_num;
    logic [15:0]   next_code;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q  <= AN_NONE;
            seg_q <= 8'hFF;
            an_p  <= AN_NONE;
            seg_p <= 8'hFF;
        end else begin
            an_q  <= an;
            seg_q <= seg;
            an_p  <= an_q;
            seg_p <= seg_q;
        end
    end

    always_comb begin
        an_cold  = an_one_cold(an_q);
        an_multi = an_multi_low(an_q);
        same     = (an_q == an_p) && (seg_q == seg_p);
        capture  = (state == STABLE) && an_cold && same &&
                   (stable_cnt == CW'(STABLE_CYCLES - 1));
        commit   = (mask == 4'b1111);
    end

    // Bad enables and blanking both abort the current digit before the FSM looks at it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= WAIT;
            stable_cnt <= '0;
            scan_error <= 1'b0;
        end else if (an_multi) begin
            scan_error <= 1'b1;
            state      <= WAIT;
        end else if (!an_cold) begin
            state <= WAIT;
        end else begin
            case (state)
                WAIT: begin
                    state      <= STABLE;
                    stable_cnt <= '0;
                end
                STABLE: begin
                    if (!same)
                        stable_cnt <= '0;
                    else if (capture)
                        state <= HOLD;
                    else
                        stable_cnt <= stable_cnt + 1'b1;
                end
                HOLD: begin
                    if (an_q != an_p)
                        state <= WAIT;
                end
                default: state <= WAIT;
            endcase
        end
    end

    // A capture landing on the commit edge starts the next frame's mask
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask <= 4'b0000;
            for (int i = 0; i < 4; i++)
                shadow[i] <= 8'hFF;
        end else begin
            if (capture)
                shadow[an_index(an_q)] <= seg_q;
            mask <= (commit ? 4'b0000 : mask) | (capture ? ~an_q : 4'b0000);
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_dec
        fnd_seg_decode u_dec (
            .pattern (shadow[g][6:0]),
            .result  (dec[g])
        );
    end

    always_comb begin
        next_num  = 1'b1;
        next_code = '0;
        for (int i = 0; i < 4; i++) begin
            next_code[4*i +: 4] = dec[i][3:0];
            if (dec[i][3:0] > 4'd9)
                next_num = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_code  <= 16'hFFFF;
            dp          <= 4'b0000;
            digit_unk   <= 4'b0000;
            frame_valid <= 1'b0;
            frame_num   <= 1'b0;
        end else begin
            frame_valid <= commit;
            if (commit) begin
                digit_code <= next_code;
                frame_num  <= next_num;
                for (int i = 0; i < 4; i++) begin
                    dp[i]        <= ~shadow[i][7];
                    digit_unk[i] <= dec[i][4];
                end
            end
        end
    end

    // Counter restarts on the commit edge so stale drops together with frame_valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stale_cnt <= '0;
        else if (commit)
            stale_cnt <= '0;
        else if (stale_cnt != TW'(TIMEOUT_CYCLES))
            stale_cnt <= stale_cnt + 1'b1;
    end

    assign stale = (stale_cnt == TW'(TIMEOUT_CYCLES));

`ifdef FND_SCAN_BIN_EN
    logic [15:0] conv_digits;
    logic [1:0]  conv_step;
    logic        conv_busy;
    logic [13:0] acc, acc_next;

    assign acc_next = acc * 14'd10 + {10'd0, conv_digits[15:12]};

    // Horner pass, most significant digit first; a new commit restarts or cancels it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conv_digits <= '0;
            conv_step   <= '0;
            conv_busy   <= 1'b0;
            acc         <= '0;
            bin_value   <= '0;
            bin_valid   <= 1'b0;
        end else begin
            bin_valid <= 1'b0;
            if (commit) begin
                conv_busy   <= next_num;
                conv_step   <= '0;
                acc         <= '0;
                conv_digits <= next_code;
            end else if (conv_busy) begin
                acc         <= acc_next;
                conv_digits <= conv_digits << 4;
                conv_step   <= conv_step + 1'b1;
                if (conv_step == 2'd3) begin
                    bin_value <= acc_next;
                    bin_valid <= 1'b1;
                    conv_busy <= 1'b0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Self-checking bench for fnd_scan_decoder: table-driven frames, randomized frames
// against a lookup-based model, and hand-written multi-cycle corner sequences.
module tb_fnd_scan_decoder;

    localparam int STABLE  = 16;
    localparam int TIMEOUT = 2000;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] digit_code;
    logic [3:0]  dp, digit_unk;
    logic        frame_valid, frame_num, scan_error, stale;
`ifdef FND_SCAN_BIN_EN
    logic [13:0] bin_value;
    logic        bin_valid;
`endif

    fnd_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .an          (an),
        .seg         (seg),
        .digit_code  (digit_code),
        .dp          (dp),
        .digit_unk   (digit_unk),
        .frame_valid (frame_valid),
        .frame_num   (frame_num),
        .scan_error  (scan_error),
        .stale       (stale)
`ifdef FND_SCAN_BIN_EN
        ,
        .bin_value   (bin_value),
        .bin_valid   (bin_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] segs;
        logic [15:0] code;
        logic [3:0]  dpv;
        logic [3:0]  unk;
        logic        num;
    } frame_vec_t;

    // Index = digit code; entry 15 is the blank pattern
    logic [6:0] pat_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h09, 7'h46, 7'h0C, 7'h06, 7'h7F};

    int vectors = 0, miscompares = 0;
    int cyc = 0, fv_count = 0, fv_cyc = 0, fv_before = 0;
    logic [15:0] lat_code;
    logic [3:0]  lat_dp, lat_unk;
    logic        lat_num, lat_stale;
    int bin_count = 0, bin_cyc = 0, bin_before = 0;
    logic [13:0] lat_bin = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin
            fv_count  <= fv_count + 1;
            fv_cyc    <= cyc;
            lat_code  <= digit_code;
            lat_dp    <= dp;
            lat_unk   <= digit_unk;
            lat_num   <= frame_num;
            lat_stale <= stale;
        end
`ifdef FND_SCAN_BIN_EN
        if (bin_valid) begin
            bin_count <= bin_count + 1;
            bin_cyc   <= cyc;
            lat_bin   <= bin_value;
        end
`endif
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [4:0] modelDecode(input logic [7:0] s);
        for (int c = 0; c < 16; c++)
            if (s[6:0] == pat_tab[c]) return {1'b0, 4'(c)};
        return {1'b1, 4'hF};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Called at a negedge; drives one bus value for the given number of cycles
    task automatic applyStimulus(input logic [3:0] a, input logic [7:0] s, input int cycles);
        an  = a;
        seg = s;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic showDigit(input int pos, input logic [7:0] s, input int hold);
        logic [3:0] a;
        a = 4'b1111;
        a[pos] = 1'b0;
        applyStimulus(a, s, hold);
        applyStimulus(4'b1111, 8'hFF, 2);
    endtask

    task automatic scanFrame(input logic [31:0] segs, input int hold);
        for (int i = 3; i >= 0; i--)
            showDigit(i, segs[8*i +: 8], hold);
    endtask

    task automatic markFrame();
        fv_before  = fv_count;
        bin_before = bin_count;
    endtask

    task automatic doReset();
        an    = 4'b1111;
        seg   = 8'hFF;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkFrame(input string name, input logic [15:0] ecode, input logic [3:0] edp,
                              input logic [3:0] eunk, input logic exp_num);
        checkOutput({name, ".frames"}, fv_count - fv_before, 1);
        checkOutput({name, ".code"}, lat_code, ecode);
        checkOutput({name, ".dp"}, lat_dp, edp);
        checkOutput({name, ".unk"}, lat_unk, eunk);
        checkOutput({name, ".num"}, lat_num, exp_num);
`ifdef FND_SCAN_BIN_EN
        if (exp_num) begin
            int exp_bin;
            exp_bin = int'(ecode[15:12]) * 1000 + int'(ecode[11:8]) * 100 +
                      int'(ecode[7:4]) * 10 + int'(ecode[3:0]);
            checkOutput({name, ".bin_pulses"}, bin_count - bin_before, 1);
            checkOutput({name, ".bin_latency"}, bin_cyc - fv_cyc, 4);
            checkOutput({name, ".bin_value"}, lat_bin, exp_bin);
        end else begin
            checkOutput({name, ".bin_pulses"}, bin_count - bin_before, 0);
        end
`endif
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, ".code"}, digit_code, 16'hFFFF);
        checkOutput({name, ".dp"}, dp, 0);
        checkOutput({name, ".unk"}, digit_unk, 0);
        checkOutput({name, ".fv"}, frame_valid, 0);
        checkOutput({name, ".num"}, frame_num, 0);
        checkOutput({name, ".err"}, scan_error, 0);
        checkOutput({name, ".stale"}, stale, 0);
`ifdef FND_SCAN_BIN_EN
        checkOutput({name, ".bin_value"}, bin_value, 0);
        checkOutput({name, ".bin_valid"}, bin_valid, 0);
`endif
    endtask

    initial begin
        frame_vec_t vecs [6];
        int guard;

        vecs[0] = '{32'hF9A4B099, 16'h1234, 4'b0000, 4'b0000, 1'b1};
        vecs[1] = '{32'hC786C1A4, 16'hFEF2, 4'b0000, 4'b1010, 1'b0};
        vecs[2] = '{32'h9080F882, 16'h9876, 4'b0000, 4'b0000, 1'b1};
        vecs[3] = '{32'h8889C68C, 16'hABCD, 4'b0000, 4'b0000, 1'b0};
        vecs[4] = '{32'h86FF0079, 16'hEF81, 4'b0011, 4'b0000, 1'b0};
        vecs[5] = '{32'hC0924092, 16'h0505, 4'b0010, 4'b0000, 1'b1};

        reset = 1'b1;
        an    = 4'b1111;
        seg   = 8'hFF;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            markFrame();
            scanFrame(vecs[v].segs, 100);
            checkFrame($sformatf("table%0d", v), vecs[v].code, vecs[v].dpv, vecs[v].unk, vecs[v].num);
        end

        for (int r = 0; r < 8; r++) begin
            logic [31:0] segs;
            logic [15:0] ec;
            logic [3:0]  edp, eun;
            logic        en;
            en = 1'b1;
            for (int d = 0; d < 4; d++) begin
                logic [7:0] s;
                logic [4:0] m;
                int pick;
                pick = $urandom_range(0, 3);
                if (pick < 2)
                    s = {1'($urandom_range(0, 1)), pat_tab[$urandom_range(0, 9)]};
                else if (pick == 2)
                    s = {1'($urandom_range(0, 1)), pat_tab[$urandom_range(0, 15)]};
                else
                    s = 8'($urandom);
                m = modelDecode(s);
                segs[8*d +: 8] = s;
                ec[4*d +: 4]   = m[3:0];
                eun[d]         = m[4];
                edp[d]         = ~s[7];
                if (m[3:0] > 4'd9) en = 1'b0;
            end
            markFrame();
            scanFrame(segs, $urandom_range(40, 80));
            checkFrame($sformatf("rand%0d", r), ec, edp, eun, en);
        end

        // Digits too short to capture, then long enough
        doReset();
        markFrame();
        scanFrame(32'hF9A4B099, 10);
        checkOutput("short.frames", fv_count - fv_before, 0);
        markFrame();
        scanFrame(32'hF9A4B099, 24);
        checkFrame("longer", 16'h1234, 4'b0000, 4'b0000, 1'b1);

        // Multi-low an glitch is sticky and does not corrupt the frame
        doReset();
        checkOutput("err.initial", scan_error, 0);
        markFrame();
        showDigit(3, 8'hF9, 100);
        showDigit(2, 8'hA4, 100);
        applyStimulus(4'b1100, 8'hFF, 1);
        applyStimulus(4'b1111, 8'hFF, 2);
        showDigit(1, 8'hB0, 100);
        showDigit(0, 8'h99, 100);
        checkFrame("err.frame", 16'h1234, 4'b0000, 4'b0000, 1'b1);
        checkOutput("err.set", scan_error, 1);
        markFrame();
        scanFrame(32'hC0924092, 100);
        checkFrame("err.next", 16'h0505, 4'b0010, 4'b0000, 1'b1);
        checkOutput("err.sticky", scan_error, 1);

        // Stale after the scan stops, cleared by the next frame
        doReset();
        markFrame();
        scanFrame(32'hF9A4B099, 100);
        checkFrame("stale.pre", 16'h1234, 4'b0000, 4'b0000, 1'b1);
        guard = 0;
        while (cyc != fv_cyc + TIMEOUT - 1 && guard < TIMEOUT + 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("stale.reach", guard < TIMEOUT + 200, 1);
        checkOutput("stale.before", stale, 0);
        @(negedge clk);
        checkOutput("stale.set", stale, 1);
        repeat (50) @(negedge clk);
        checkOutput("stale.hold", stale, 1);
        markFrame();
        scanFrame(32'hC0C0C0C0, 100);
        checkFrame("stale.resume", 16'h0000, 4'b0000, 4'b0000, 1'b1);
        checkOutput("stale.at_fv", lat_stale, 0);
        checkOutput("stale.clear", stale, 0);

        // Asynchronous reset after two captured digits discards the partial frame
        showDigit(3, 8'h90, 100);
        showDigit(2, 8'h80, 100);
        #2 reset = 1'b1;
        #1 checkResetValues("midreset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        markFrame();
        showDigit(1, 8'hF8, 100);
        showDigit(0, 8'h82, 100);
        checkOutput("midreset.partial", fv_count - fv_before, 0);
        showDigit(3, 8'h90, 100);
        showDigit(2, 8'h80, 100);
        checkFrame("midreset.frame", 16'h9876, 4'b0000, 4'b0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
